// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared sizing and types for the FIFO write-port arbiter.
// CNT_WIDTH is derived so the credit counter can hold the value DEPTH itself.
package fifo_arb_pkg;

  function automatic int clog2(input int value);
    int result;
    int remain;
    result = 32'sd0;
    remain = value - 32'sd1;
    while (remain > 32'sd0) begin
      result = result + 32'sd1;
      remain = remain >>> 32'sd1;
    end
    return result;
  endfunction

  localparam int NUM_REQ   = 32'sd4;
  localparam int WIDTH     = 32'sd8;
  localparam int DEPTH     = 32'sd16;
  localparam int CNT_WIDTH = clog2(DEPTH) + 32'sd1;
  localparam int PTR_WIDTH = clog2(NUM_REQ);

  typedef enum logic [1:0] {
    CR_HOLD     = 2'd0,
    CR_TAKE     = 2'd1,
    CR_RETURN   = 2'd2,
    CR_SATURATE = 2'd3
  } credit_op_e;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side and FIFO-side signals of the write-port arbiter.
interface fifo_wr_arbiter_if;
  import fifo_arb_pkg::*;

  logic [NUM_REQ-1:0]       req_i;
  logic [NUM_REQ*WIDTH-1:0] wdata_i;
  logic [NUM_REQ-1:0]       gnt_o;
  logic                     fifo_wr_en_o;
  logic [WIDTH-1:0]         fifo_wdata_o;
  logic                     fifo_rd_done_i;
  logic [CNT_WIDTH-1:0]     credits_o;
  logic                     err_o;

  modport slave (
    input  req_i, wdata_i, fifo_rd_done_i,
    output gnt_o, fifo_wr_en_o, fifo_wdata_o, credits_o, err_o
  );

  modport master (
    output req_i, wdata_i, fifo_rd_done_i,
    input  gnt_o, fifo_wr_en_o, fifo_wdata_o, credits_o, err_o
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or above ptr, wrapping.
module rr_arbiter
  import fifo_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0]   req,
  input  logic [PTR_WIDTH-1:0] ptr,
  input  logic                 enable,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [PTR_WIDTH-1:0] winner,
  output logic                 valid
);

  logic [PTR_WIDTH-1:0] idx_s;
  logic                 take_s;

  function automatic logic [PTR_WIDTH-1:0] wrap_add(input logic [PTR_WIDTH-1:0] base,
                                                    input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NUM_REQ) begin
      sum = sum - NUM_REQ;
    end else begin
      sum = sum;
    end
    return PTR_WIDTH'(sum);
  endfunction

  // Scan from ptr upward; the first requester seen claims the grant.
  always_comb begin
    gnt    = '0;
    winner = '0;
    valid  = 1'b0;
    idx_s  = '0;
    take_s = 1'b0;
    if (enable) begin
      for (int i = 32'sd0; i < NUM_REQ; i++) begin
        idx_s  = wrap_add(ptr, i);
        take_s = req[idx_s] & ~valid;
        gnt    = gnt | (NUM_REQ'(take_s) << idx_s);
        winner = take_s ? idx_s : winner;
        valid  = valid | take_s;
      end
    end else begin
      gnt    = '0;
      winner = '0;
      valid  = 1'b0;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares one FIFO write port among NUM_REQ requesters, round-robin,
// throttled by a local count of free FIFO slots rather than the full flag.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  fifo_wr_arbiter_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] CREDIT_FULL = CNT_WIDTH'(DEPTH);
  localparam logic [PTR_WIDTH-1:0] PTR_LAST    = PTR_WIDTH'(NUM_REQ - 32'sd1);

  logic [PTR_WIDTH-1:0] ptr_r;
  logic [CNT_WIDTH-1:0] credits_r;
  logic                 wr_en_r;
  logic [WIDTH-1:0]     wdata_r;
  logic                 err_r;

  logic                 enable_s;
  logic [NUM_REQ-1:0]   gnt_s;
  logic [PTR_WIDTH-1:0] winner_s;
  logic                 valid_s;
  logic [PTR_WIDTH-1:0] ptr_next_s;
  logic [WIDTH-1:0]     sel_word_s;
  credit_op_e           credit_op_s;

  // Reset also masks the grant so nothing is handed out while state is cleared.
  assign enable_s = ~rst_i & (credits_r != '0);

  rr_arbiter u_rr (
    .req    (bus.req_i),
    .ptr    (ptr_r),
    .enable (enable_s),
    .gnt    (gnt_s),
    .winner (winner_s),
    .valid  (valid_s)
  );

  // Winner's word and the pointer position just past the winner.
  always_comb begin
    sel_word_s = bus.wdata_i[int'(winner_s)*WIDTH +: WIDTH];
    if (winner_s == PTR_LAST) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = winner_s + 1'b1;
    end
  end

  // Credit action; a read on a full count is spurious and only flags an error.
  always_comb begin
    credit_op_s = CR_HOLD;
    case ({valid_s, bus.fifo_rd_done_i})
      2'b10: credit_op_s = CR_TAKE;
      2'b01: begin
        if (credits_r == CREDIT_FULL) begin
          credit_op_s = CR_SATURATE;
        end else begin
          credit_op_s = CR_RETURN;
        end
      end
      default: credit_op_s = CR_HOLD;
    endcase
  end

  // Pointer, credit counter, write register and sticky error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_r     <= '0;
      credits_r <= CREDIT_FULL;
      wr_en_r   <= 1'b0;
      wdata_r   <= '0;
      err_r     <= 1'b0;
    end else begin
      if (valid_s) begin
        wdata_r <= sel_word_s;
        ptr_r   <= ptr_next_s;
      end
      wr_en_r <= valid_s;
      case (credit_op_s)
        CR_TAKE:     credits_r <= credits_r - 1'b1;
        CR_RETURN:   credits_r <= credits_r + 1'b1;
        CR_SATURATE: err_r     <= 1'b1;
        default:     credits_r <= credits_r;
      endcase
    end
  end

  assign bus.gnt_o        = gnt_s;
  assign bus.fifo_wr_en_o = wr_en_r;
  assign bus.fifo_wdata_o = wdata_r;
  assign bus.credits_o    = credits_r;
  assign bus.err_o        = err_r;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Table-driven bench for fifo_wr_arbiter; written words are tracked in a scoreboard queue.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       rd;
    logic [3:0] exp_gnt;
    logic [4:0] exp_cred;
    logic       exp_err;
  } vec_t;

  logic       clk;
  logic       rst;
  vec_t       tbl[$];
  logic [7:0] sb_q[$];
  logic [5:0] seq [4];
  int         checks;
  int         errors;

  fifo_wr_arbiter_if bus_if ();

  fifo_wr_arbiter dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, n, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] req, input logic rd,
                     input logic [3:0] g, input logic [4:0] c, input logic e);
    vec_t v;
    v.rst = r; v.req = req; v.rd = rd; v.exp_gnt = g; v.exp_cred = c; v.exp_err = e;
    tbl.push_back(v);
  endtask

  task automatic add_rst(input logic [3:0] req);
    add(1'b1, req, 1'b0, 4'b0000, 5'd16, 1'b0);
  endtask

  task automatic apply(input int n, input vec_t v);
    int         gi;
    logic       exp_wr;
    logic [7:0] word;
    rst = v.rst;
    bus_if.req_i = v.req;
    bus_if.fifo_rd_done_i = v.rd;
    for (int r = 0; r < 4; r++) bus_if.wdata_i[r*8 +: 8] = {2'(r), seq[r]};
    #4;
    chk("gnt", n, 32'(bus_if.gnt_o), 32'(v.exp_gnt));
    exp_wr = (v.exp_gnt != 4'b0000);
    gi = 0;
    for (int r = 0; r < 4; r++) if (v.exp_gnt[r]) gi = r;
    if (exp_wr) sb_q.push_back({2'(gi), seq[gi]});
    @(posedge clk);
    #1;
    if (exp_wr) seq[gi] = seq[gi] + 6'd1;
    chk("wr_en", n, 32'(bus_if.fifo_wr_en_o), 32'(exp_wr));
    if (bus_if.fifo_wr_en_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wdata vec %0d: got write %0h expected no write", n, bus_if.fifo_wdata_o);
      end else begin
        word = sb_q.pop_front();
        chk("wdata", n, 32'(bus_if.fifo_wdata_o), 32'(word));
      end
    end else begin
      sb_q.delete();
    end
    if (v.rst) chk("rst_wdata", n, 32'(bus_if.fifo_wdata_o), 32'd0);
    chk("credits", n, 32'(bus_if.credits_o), 32'(v.exp_cred));
    chk("err", n, 32'(bus_if.err_o), 32'(v.exp_err));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus_if.req_i = 4'b0000;
    bus_if.fifo_rd_done_i = 1'b0;
    bus_if.wdata_i = 32'h0000_0000;
    for (int r = 0; r < 4; r++) seq[r] = 6'd0;

    // Single requester: 16 grants then starved, no reads.
    add_rst(4'b0000);
    for (int i = 0; i < 20; i++) begin
      if (i < 16) add(1'b0, 4'b0001, 1'b0, 4'b0001, 5'(15 - i), 1'b0);
      else        add(1'b0, 4'b0001, 1'b0, 4'b0000, 5'd0, 1'b0);
    end
    // All four requesting, reads interleaved.
    add_rst(4'b0000);
    add(1'b0, 4'b1111, 1'b0, 4'b0001, 5'd15, 1'b0);
    add(1'b0, 4'b1111, 1'b1, 4'b0010, 5'd15, 1'b0);
    add(1'b0, 4'b1111, 1'b0, 4'b0100, 5'd14, 1'b0);
    add(1'b0, 4'b1111, 1'b1, 4'b1000, 5'd14, 1'b0);
    add(1'b0, 4'b1111, 1'b0, 4'b0001, 5'd13, 1'b0);
    add(1'b0, 4'b1111, 1'b1, 4'b0010, 5'd13, 1'b0);
    // Drain to one credit with requester 2 only.
    for (int i = 0; i < 12; i++) add(1'b0, 4'b0100, 1'b0, 4'b0100, 5'(12 - i), 1'b0);
    // Credit boundary: grant plus read at one credit, then last credit taken (ptr -> 3).
    add(1'b0, 4'b0010, 1'b1, 4'b0010, 5'd1, 1'b0);
    add(1'b0, 4'b0100, 1'b0, 4'b0100, 5'd0, 1'b0);
    // Credit stall fairness: 3 then 1 once credits return.
    add(1'b0, 4'b1010, 1'b0, 4'b0000, 5'd0, 1'b0);
    add(1'b0, 4'b1010, 1'b0, 4'b0000, 5'd0, 1'b0);
    add(1'b0, 4'b1010, 1'b0, 4'b0000, 5'd0, 1'b0);
    add(1'b0, 4'b1010, 1'b1, 4'b0000, 5'd1, 1'b0);
    add(1'b0, 4'b1010, 1'b0, 4'b1000, 5'd0, 1'b0);
    add(1'b0, 4'b0010, 1'b1, 4'b0000, 5'd1, 1'b0);
    add(1'b0, 4'b0010, 1'b0, 4'b0010, 5'd0, 1'b0);
    // Spurious read after reset: saturate and sticky error.
    add_rst(4'b0000);
    add(1'b0, 4'b0000, 1'b1, 4'b0000, 5'd16, 1'b1);
    add(1'b0, 4'b0000, 1'b0, 4'b0000, 5'd16, 1'b1);
    add(1'b0, 4'b0000, 1'b0, 4'b0000, 5'd16, 1'b1);
    add(1'b0, 4'b0001, 1'b0, 4'b0001, 5'd15, 1'b1);
    add(1'b0, 4'b0000, 1'b1, 4'b0000, 5'd16, 1'b1);
    add_rst(4'b0000);
    // Reset in the middle of a burst.
    add(1'b0, 4'b1111, 1'b0, 4'b0001, 5'd15, 1'b0);
    add(1'b0, 4'b1111, 1'b0, 4'b0010, 5'd14, 1'b0);
    add(1'b0, 4'b1111, 1'b1, 4'b0100, 5'd14, 1'b0);
    add_rst(4'b1111);
    add(1'b0, 4'b1111, 1'b0, 4'b0001, 5'd15, 1'b0);
    add(1'b0, 4'b1111, 1'b0, 4'b0010, 5'd14, 1'b0);
    add(1'b0, 4'b0000, 1'b0, 4'b0000, 5'd14, 1'b0);

    for (int n = 0; n < tbl.size(); n++) apply(n, tbl[n]);

    chk("sb_left", tbl.size(), 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
